// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the sum accumulator: readout state encoding,
// byte/counter widths and the derived readout byte count.
package sum_accumulator_pkg;
  localparam int BYTE_W      = 8;
  localparam int CNT_W       = 8;
  localparam int ADDEND_W    = 9;
  localparam int ACC_W_DFLT  = 16;
  localparam int NBYTES_DFLT = ACC_W_DFLT / BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_SEND_CNT = 2'd2
  } state_t;

  function automatic int nbytes(input int acc_w);
    return acc_w / BYTE_W;
  endfunction
endpackage

// File: rtl/sum_accumulator_sat_add.sv
// Unsigned saturating adder: ACC_W-bit running value plus a 9-bit addend,
// clamping to all-ones and flagging when the true sum does not fit.
module sat_add
  import sum_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DFLT
) (
  input  logic [ACC_W-1:0]    i_a,
  input  logic [ADDEND_W-1:0] i_b,
  output logic [ACC_W-1:0]    o_sum,
  output logic                o_ovf
);
  logic [ACC_W:0] w_full;

  assign w_full = {1'b0, i_a} + {{(ACC_W + 1 - ADDEND_W){1'b0}}, i_b};
  assign o_ovf  = w_full[ACC_W];
  assign o_sum  = o_ovf ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
endmodule

// File: rtl/sum_accumulator.sv
// Saturating accumulator of adder results with a sample counter, plus a
// snapshot readout that streams total (MS byte first) then count bytewise.
//
//  state       | meaning
//  ST_IDLE     | no readout; waiting for rd_req
//  ST_SEND     | presenting snapshot total byte r_idx
//  ST_SEND_CNT | presenting snapshot sample count
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DFLT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sum_in,
  input  logic       carry_in,
  input  logic       sum_valid,
  input  logic       clear,
  input  logic       rd_req,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       sat_flag
);
  localparam int NBYTES = nbytes(ACC_W);
  localparam int IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  logic [ACC_W-1:0]    r_total;
  logic [CNT_W-1:0]    r_count;
  logic                r_sat;
  logic [ACC_W-1:0]    r_snap_total;
  logic [CNT_W-1:0]    r_snap_count;
  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;

  state_t              w_state_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [ADDEND_W-1:0] w_addend;
  logic [ACC_W-1:0]    w_sum;
  logic                w_ovf;
  logic [ACC_W-1:0]    w_shifted;
  logic [BYTE_W-1:0]   w_sel_byte;

  assign w_addend = {carry_in, sum_in};

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .i_a   (r_total),
    .i_b   (w_addend),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  // Accumulation runs every cycle regardless of readout activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_total <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (clear) begin
      r_sat <= 1'b0;
      if (sum_valid) begin
        r_total <= {{(ACC_W - ADDEND_W){1'b0}}, w_addend};
        r_count <= CNT_W'(1);
      end else begin
        r_total <= '0;
        r_count <= '0;
      end
    end else if (sum_valid) begin
      r_total <= w_sum;
      r_count <= r_count + CNT_W'(1);
      if (w_ovf) r_sat <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_total <= '0;
      r_snap_count <= '0;
    end else if (r_state == ST_IDLE && rd_req) begin
      r_snap_total <= r_total;
      r_snap_count <= r_count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign w_shifted  = r_snap_total >> {r_idx, 3'b000};
  assign w_sel_byte = w_shifted[BYTE_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    out_valid   = 1'b0;
    out_data    = '0;
    case (r_state)
      ST_IDLE: begin
        if (rd_req) begin
          w_state_nxt = ST_SEND;
          w_idx_nxt   = IDX_LAST;
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_data  = w_sel_byte;
        if (out_ready) begin
          if (r_idx == '0) w_state_nxt = ST_SEND_CNT;
          else             w_idx_nxt   = r_idx - IDX_W'(1);
        end
      end
      ST_SEND_CNT: begin
        out_valid = 1'b1;
        out_data  = r_snap_count;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy     = (r_state != ST_IDLE);
  assign sat_flag = r_sat;
endmodule
